tpc_warp_dispatch: RTL and testbench
====================================

Name: tpc_warp_dispatch

Overview:
Upstream neighbour of the per-SM warp-assignment stage. Accepts one kernel launch at a time, given as a total warp count. Issues one warp-assignment request per cycle to one of NUM_SM SM cores, chosen by round-robin among ready cores. Counts completion responses returned by the cores and pulses kernel_done_o once every issued warp has completed.

Parameters:
NUM_SM, 4, number of SM cores served (≥1)
KWARP_W, 16, width of the kernel warp count and internal counters
DEPTH_WARP, `DEPTH_WARP, width of the per-SM warp id (from define.sv)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
kernel_valid_i  input  1  new kernel launch offered
kernel_ready_o  output  1  dispatcher idle and able to take a launch
kernel_num_warps_i  input  KWARP_W  total warps in the launched kernel
kernel_done_o  output  1  one-cycle pulse: all warps of current kernel completed
busy_o  output  1  kernel in progress (state != IDLE)
err_o  output  1  sticky: completion received beyond issued count
sm_req_valid_o  output  NUM_SM  per-SM warp request; at most one bit set
sm_req_ready_i  input  NUM_SM  per-SM ready to accept a warp
sm_rsp_valid_i  input  NUM_SM  per-SM warp-completion valid
sm_rsp_ready_o  output  NUM_SM  per-SM completion ready
sm_rsp_wid_i  input  NUM_SM*DEPTH_WARP  flattened per-SM completed warp id; SM k at bits [k*DEPTH_WARP +: DEPTH_WARP]
dbg_last_wid_o  output  DEPTH_WARP  wid of lowest-index SM completion accepted in most recent completion cycle

Behaviour:
- Reset: clk / rst_n as decided. All outputs 0 except kernel_ready_o=1. State=IDLE, counters=0, rr pointer=0, err=0. Reset mid-kernel discards all progress; in-flight SM completions after reset are not counted.
- States: IDLE, DISPATCH, DRAIN, DONE. Registers: total, issued_cnt, done_cnt (all KWARP_W), rr_ptr (clog2(NUM_SM), min 1 bit).
- IDLE:
  - kernel_ready_o=1; sm_rsp_ready_o=0.
  - Launch accepted on valid&ready: total<=num_warps, issued_cnt<=0, done_cnt<=0, err<=0.
  - Next state: DONE if num_warps==0, else DISPATCH.
- DISPATCH:
  - sel = first SM index at or after rr_ptr (cyclic) with sm_req_ready_i set. Drive sm_req_valid_o=onehot(sel) combinationally; all zeros if no SM is ready.
  - Legal because SM ready depends only on its registered state, never on valid.
  - Accept = valid&ready on sel. On accept: issued_cnt++, rr_ptr<=sel+1 modulo NUM_SM.
  - On the accept where issued_cnt+1==total: go to DRAIN. Valid is 0 from that point.
- DISPATCH and DRAIN:
  - sm_rsp_ready_o = all ones; every valid completion is accepted the same cycle.
  - done_cnt += popcount(sm_rsp_valid_i).
  - If done_cnt+popcount > issued_cnt (counting an issue accepted the same cycle): set err_o, and saturate done_cnt at issued_cnt.
- DRAIN: when done_cnt+popcount == total, go to DONE.
- DONE: kernel_done_o=1 for exactly one cycle, sm_rsp_ready_o=0; next state IDLE. kernel_ready_o stays 0 in DONE.
- Latency:
  - Launch to first sm_req_valid_o: 1 cycle.
  - Last completion accepted to kernel_done_o: 1 cycle.
  - A zero-warp launch gives kernel_done_o 1 cycle after accept.
- A completion and an issue may occur in the same cycle; both counters update independently.
- All counters wrap-free: total < 2^KWARP_W guaranteed by width.
- dbg_last_wid_o updates only in cycles with at least one accepted completion.

Decomposition:
- define.sv supplies NUM_WARP / DEPTH_WARP.
- Shared package tpc_pkg holds the state enum typedef (IDLE/DISPATCH/DRAIN/DONE) and a popcount function.
- One sub-module, tpc_rr_pick: purely combinational rotating-priority picker. Inputs: req vector, pointer. Outputs: one-hot grant, binary index, any-grant flag.

Test Plan:
- NUM_SM=4, all ready, launch 6 warps → grants SM0,1,2,3,0,1 on consecutive cycles; issued_cnt=6; state DRAIN.
- Then return 6 completions, 3 in one cycle (popcount=3) → done_cnt=6; kernel_done_o pulses exactly 1 cycle later; kernel_ready_o=1 the cycle after.
- Launch with num_warps=0 → no sm_req_valid_o ever; kernel_done_o pulse 1 cycle after accept.
- rr_ptr=1, sm_req_ready_i=4'b1001 → grant SM3, then rr_ptr=0 → grant SM0; SM1/2 never granted while not ready.
- Launch 2 warps, return 3 completions → err_o=1, done_cnt capped at 2, kernel still completes; err_o cleared on next launch.
- Assert rst_n low mid-DISPATCH after 3 of 8 issued → outputs return to reset values; next launch of 2 warps completes normally.

Source files
------------

// File: rtl/tpc_pkg.sv
// Shared types and helpers for the TPC warp dispatcher.
//   tpc_state_e     : dispatcher FSM states
//   TPC_DEPTH_WARP  : per-SM warp id width, taken from define.sv
//   popcount()      : number of set bits in a vector of up to 32 bits
package tpc_pkg;
`include "define.sv"

    localparam int unsigned TPC_DEPTH_WARP = `DEPTH_WARP;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        DONE
    } tpc_state_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/define.sv
// Global build defines shared by the TPC dispatch slice.
//   NUM_WARP   : warps resident per SM core
//   DEPTH_WARP : width of a per-SM warp id
`ifndef TPC_DEFINE_SV
`define TPC_DEFINE_SV
`define NUM_WARP   8
`define DEPTH_WARP 3
`endif

// File: rtl/tpc_rr_pick.sv
// Combinational rotating-priority picker.
//   req_i : request vector, one bit per requester
//   ptr_i : index that gets highest priority this cycle
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : binary index of the granted requester
//   any_o : at least one request was granted
module tpc_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic [PTR_W-1:0] k;

    // Walk the requesters cyclically starting at ptr_i; first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            k = PTR_W'((32'(ptr_i) + off) % N);
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/tpc_warp_dispatch.sv
// Kernel-level warp dispatcher: takes one kernel launch (a warp count),
// issues one warp request per cycle to a ready SM chosen round-robin, counts
// completions and pulses kernel_done_o once every issued warp has completed.
//   clk, rst_n          : clock, asynchronous active-low reset
//   kernel_*            : launch handshake, warp count, done pulse
//   busy_o / err_o      : kernel in progress / sticky over-completion error
//   sm_req_*            : per-SM warp request (valid at most one-hot)
//   sm_rsp_*            : per-SM completion handshake and completed warp id
//   dbg_last_wid_o      : wid from lowest-index SM in the latest completion cycle
module tpc_warp_dispatch
    import tpc_pkg::*;
#(
    parameter int unsigned NUM_SM     = 4,
    parameter int unsigned KWARP_W    = 16,
    parameter int unsigned DEPTH_WARP = TPC_DEPTH_WARP
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         kernel_valid_i,
    output logic                         kernel_ready_o,
    input  logic [KWARP_W-1:0]           kernel_num_warps_i,
    output logic                         kernel_done_o,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [NUM_SM-1:0]            sm_req_valid_o,
    input  logic [NUM_SM-1:0]            sm_req_ready_i,
    input  logic [NUM_SM-1:0]            sm_rsp_valid_i,
    output logic [NUM_SM-1:0]            sm_rsp_ready_o,
    input  logic [NUM_SM*DEPTH_WARP-1:0] sm_rsp_wid_i,
    output logic [DEPTH_WARP-1:0]        dbg_last_wid_o
);

    localparam int unsigned PTR_W = (NUM_SM > 1) ? $clog2(NUM_SM) : 1;

    tpc_state_e            state_q;
    logic [KWARP_W-1:0]    total_q, issued_q, done_q;
    logic [KWARP_W-1:0]    issued_d, done_d, done_sum, rsp_cnt;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  err_q;
    logic [DEPTH_WARP-1:0] last_wid_q, low_wid;
    logic [NUM_SM-1:0]     gnt;
    logic [PTR_W-1:0]      sel;
    logic                  any_gnt, active, issue_acc, over, low_found;

    tpc_rr_pick #(
        .N     (NUM_SM),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i (sm_req_ready_i),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (sel),
        .any_o (any_gnt)
    );

    always_comb begin
        active    = (state_q == DISPATCH) || (state_q == DRAIN);
        // The picker only grants ready SMs, so any grant is an accepted issue.
        issue_acc = (state_q == DISPATCH) && any_gnt;
        issued_d  = issued_q + KWARP_W'(issue_acc);
        rsp_cnt   = active ? KWARP_W'(popcount(32'(sm_rsp_valid_i))) : '0;
        done_sum  = done_q + rsp_cnt;
        // Over-completion is judged against the issue count including this cycle's issue.
        over      = done_sum > issued_d;
        done_d    = over ? issued_d : done_sum;
        rr_ptr_d  = (32'(sel) == NUM_SM - 1) ? '0 : sel + PTR_W'(1);
    end

    always_comb begin
        low_wid   = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SM; i++) begin
            if (!low_found && sm_rsp_valid_i[i]) begin
                low_found = 1'b1;
                low_wid   = sm_rsp_wid_i[i*DEPTH_WARP +: DEPTH_WARP];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            total_q    <= '0;
            issued_q   <= '0;
            done_q     <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
            last_wid_q <= '0;
        end else begin
            if (active && low_found) begin
                last_wid_q <= low_wid;
            end
            case (state_q)
                IDLE: begin
                    if (kernel_valid_i) begin
                        total_q  <= kernel_num_warps_i;
                        issued_q <= '0;
                        done_q   <= '0;
                        err_q    <= 1'b0;
                        state_q  <= (kernel_num_warps_i == '0) ? DONE : DISPATCH;
                    end
                end
                DISPATCH: begin
                    issued_q <= issued_d;
                    done_q   <= done_d;
                    if (over) begin
                        err_q <= 1'b1;
                    end
                    if (issue_acc) begin
                        rr_ptr_q <= rr_ptr_d;
                        if (issued_d == total_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    done_q <= done_d;
                    if (over) begin
                        err_q <= 1'b1;
                    end
                    // done_d is saturated, so an over-completion still lands on total.
                    if (done_d == total_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        kernel_ready_o = (state_q == IDLE);
        kernel_done_o  = (state_q == DONE);
        busy_o         = (state_q != IDLE);
        err_o          = err_q;
        sm_req_valid_o = (state_q == DISPATCH) ? gnt : '0;
        sm_rsp_ready_o = active ? '1 : '0;
        dbg_last_wid_o = last_wid_q;
    end

endmodule

// File: tb/tb_tpc_warp_dispatch.sv
module tb_tpc_warp_dispatch;
    import tpc_pkg::*;

    localparam int unsigned NSM = 4;
    localparam int unsigned KW  = 16;
    localparam int unsigned DW  = TPC_DEPTH_WARP;

    logic              clk;
    logic              rst_n;
    logic              kernel_valid_i;
    logic              kernel_ready_o;
    logic [KW-1:0]     kernel_num_warps_i;
    logic              kernel_done_o;
    logic              busy_o;
    logic              err_o;
    logic [NSM-1:0]    sm_req_valid_o;
    logic [NSM-1:0]    sm_req_ready_i;
    logic [NSM-1:0]    sm_rsp_valid_i;
    logic [NSM-1:0]    sm_rsp_ready_o;
    logic [NSM*DW-1:0] sm_rsp_wid_i;
    logic [DW-1:0]     dbg_last_wid_o;

    tpc_warp_dispatch #(
        .NUM_SM     (NSM),
        .KWARP_W    (KW),
        .DEPTH_WARP (DW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .kernel_valid_i     (kernel_valid_i),
        .kernel_ready_o     (kernel_ready_o),
        .kernel_num_warps_i (kernel_num_warps_i),
        .kernel_done_o      (kernel_done_o),
        .busy_o             (busy_o),
        .err_o              (err_o),
        .sm_req_valid_o     (sm_req_valid_o),
        .sm_req_ready_i     (sm_req_ready_i),
        .sm_rsp_valid_i     (sm_rsp_valid_i),
        .sm_rsp_ready_o     (sm_rsp_ready_o),
        .sm_rsp_wid_i       (sm_rsp_wid_i),
        .dbg_last_wid_o     (dbg_last_wid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum int {OP_VEC, OP_LAUNCH, OP_RESET} op_e;

    typedef struct {
        logic [3:0]    req;
        logic [3:0]    rspr;
        logic          busy;
        logic          kready;
        logic          done;
        logic          err;
        logic [DW-1:0] dbg;
    } exp_t;

    typedef struct {
        op_e         op;
        int unsigned num;
        logic [3:0]  ready;
        logic [3:0]  rsp;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic V(input logic [3:0] ready, input logic [3:0] rsp,
                     input logic [3:0] req, input logic [3:0] rspr,
                     input logic busy, input logic kready, input logic done,
                     input logic err, input int unsigned dbg);
        vec_t v;
        v.op       = OP_VEC;
        v.num      = 0;
        v.ready    = ready;
        v.rsp      = rsp;
        v.e.req    = req;
        v.e.rspr   = rspr;
        v.e.busy   = busy;
        v.e.kready = kready;
        v.e.done   = done;
        v.e.err    = err;
        v.e.dbg    = DW'(dbg);
        vecs.push_back(v);
    endtask

    task automatic L(input int unsigned n);
        vec_t v;
        v     = '{OP_LAUNCH, 0, 4'h0, 4'h0, '{4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0}};
        v.num = n;
        vecs.push_back(v);
    endtask

    task automatic R();
        vec_t v;
        v = '{OP_RESET, 0, 4'hF, 4'hF, '{4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, '0}};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [step %0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic compare(input int idx);
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", idx, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sm_req_valid",  idx, 32'(sm_req_valid_o), 32'(e.req));
            check("sm_rsp_ready",  idx, 32'(sm_rsp_ready_o), 32'(e.rspr));
            check("busy",          idx, 32'(busy_o),         32'(e.busy));
            check("kernel_ready",  idx, 32'(kernel_ready_o), 32'(e.kready));
            check("kernel_done",   idx, 32'(kernel_done_o),  32'(e.done));
            check("err",           idx, 32'(err_o),          32'(e.err));
            check("dbg_last_wid",  idx, 32'(dbg_last_wid_o), 32'(e.dbg));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        kernel_valid_i     = 1'b0;
        kernel_num_warps_i = '0;
        sm_req_ready_i     = '0;
        sm_rsp_valid_i     = '0;
        for (int k = 0; k < int'(NSM); k++) begin
            sm_rsp_wid_i[k*DW +: DW] = DW'(k + 1);
        end

        // Fields: ready, rsp_valid | expected req, rsp_ready, busy, kready, done, err, dbg
        R();
        // 6 warps, all SMs ready: 0,1,2,3,0,1 then drain with a 3-wide completion
        L(6);
        V(4'hF, 4'h0, 4'b0001, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h0, 4'b0010, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h0, 4'b0100, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h0, 4'b1000, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h0, 4'b0001, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h0, 4'b0010, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h7, 4'b0000, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h1, 4'b0000, 4'hF, 1, 0, 0, 0, 1);
        V(4'hF, 4'h2, 4'b0000, 4'hF, 1, 0, 0, 0, 1);
        V(4'hF, 4'h4, 4'b0000, 4'hF, 1, 0, 0, 0, 2);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 1, 0, 1, 0, 3);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 0, 1, 0, 0, 3);
        // 5 warps from pointer 2 with sparse ready; issue and completion share a cycle
        L(5);
        V(4'h0, 4'h0, 4'b0000, 4'hF, 1, 0, 0, 0, 3);
        V(4'hF, 4'h0, 4'b0100, 4'hF, 1, 0, 0, 0, 3);
        V(4'h1, 4'h2, 4'b0001, 4'hF, 1, 0, 0, 0, 3);
        V(4'h9, 4'h0, 4'b1000, 4'hF, 1, 0, 0, 0, 2);
        V(4'h9, 4'h0, 4'b0001, 4'hF, 1, 0, 0, 0, 2);
        V(4'h6, 4'h0, 4'b0010, 4'hF, 1, 0, 0, 0, 2);
        V(4'hF, 4'h9, 4'b0000, 4'hF, 1, 0, 0, 0, 2);
        V(4'hF, 4'hA, 4'b0000, 4'hF, 1, 0, 0, 0, 1);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 1, 0, 1, 0, 2);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 0, 1, 0, 0, 2);
        // zero-warp kernel; completions offered in DONE/IDLE must be ignored
        L(0);
        V(4'hF, 4'hF, 4'b0000, 4'h0, 1, 0, 1, 0, 2);
        V(4'hF, 4'hF, 4'b0000, 4'h0, 0, 1, 0, 0, 2);
        // 2 warps, 3 completions: error, kernel still completes
        L(2);
        V(4'hF, 4'h0, 4'b0100, 4'hF, 1, 0, 0, 0, 2);
        V(4'hF, 4'h0, 4'b1000, 4'hF, 1, 0, 0, 0, 2);
        V(4'hF, 4'h7, 4'b0000, 4'hF, 1, 0, 0, 0, 2);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 1, 0, 1, 1, 1);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 0, 1, 0, 1, 1);
        // 8 warps, reset after 3 issued; err cleared by launch
        L(8);
        V(4'hF, 4'h0, 4'b0001, 4'hF, 1, 0, 0, 0, 1);
        V(4'hF, 4'h0, 4'b0010, 4'hF, 1, 0, 0, 0, 1);
        V(4'hF, 4'h0, 4'b0100, 4'hF, 1, 0, 0, 0, 1);
        R();
        V(4'hF, 4'hF, 4'b0000, 4'h0, 0, 1, 0, 0, 0);
        V(4'hF, 4'hF, 4'b0000, 4'h0, 0, 1, 0, 0, 0);
        // fresh 2-warp kernel after reset starts from SM0
        L(2);
        V(4'hF, 4'h0, 4'b0001, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h0, 4'b0010, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h3, 4'b0000, 4'hF, 1, 0, 0, 0, 0);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 1, 0, 1, 0, 1);
        V(4'hF, 4'h0, 4'b0000, 4'h0, 0, 1, 0, 0, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_LAUNCH: begin
                    kernel_num_warps_i = KW'(vecs[i].num);
                    kernel_valid_i     = 1'b1;
                    sm_rsp_valid_i     = '0;
                    @(negedge clk);
                    check("launch_ready", i, 32'(kernel_ready_o), 32'd1);
                    @(posedge clk);
                    #1;
                    kernel_valid_i = 1'b0;
                end
                OP_RESET: begin
                    rst_n          = 1'b0;
                    sm_req_ready_i = vecs[i].ready;
                    sm_rsp_valid_i = vecs[i].rsp;
                    sb.push_back(vecs[i].e);
                    #1;
                    compare(i);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(posedge clk);
                    #1;
                end
                default: begin
                    sm_req_ready_i = vecs[i].ready;
                    sm_rsp_valid_i = vecs[i].rsp;
                    sb.push_back(vecs[i].e);
                    @(negedge clk);
                    compare(i);
                    @(posedge clk);
                    #1;
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
